// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, writeback and issue bundle of the multi-ported register file.
// Revision: 1.0
`default_nettype none

interface regfile_mp_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_count
  );
endinterface

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write-to-read bypass and busy scoreboard.
// Revision: 1.0
`default_nettype none

module regfile_mp_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  regfile_mp_sb_if.slave    bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  // Later write ports overwrite earlier ones; a same-cycle issue overrides any clear.
  always_comb begin
    regs_d  = regs_q;
    busy_d  = busy_q;
    count_d = '0;
    for (int j = 0; j < NWR; j++) begin
      if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != '0)) begin
        regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
        busy_d[bus.wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (bus.iss_en && (bus.iss_addr != '0)) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      count_d = count_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  logic [NRD*XLEN-1:0] rd_data_w;
  logic [NRD-1:0]      rd_busy_w;

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            hit;
    rd_data_w = '0;
    rd_busy_w = '0;
    ra        = '0;
    rdat      = '0;
    hit       = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra   = bus.rd_addr[i*AW +: AW];
      rdat = regs_q[ra];
      hit  = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra)) begin
          rdat = bus.wr_data[j*XLEN +: XLEN];
          hit  = 1'b1;
        end
      end
      if (ra != '0) begin
        rd_data_w[i*XLEN +: XLEN] = rdat;
        rd_busy_w[i]              = busy_q[ra] & ~hit;
      end
    end
  end

  assign bus.rd_data    = rd_data_w;
  assign bus.rd_busy    = rd_busy_w;
  assign bus.busy_count = count_q;
endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed checks of reset, bypass, write priority and scoreboard behaviour.
// Revision: 1.0
`default_nettype none

module tb_regfile_mp_sb;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regfile_mp_sb_if #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2)) bus ();

  regfile_mp_sb #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with writes and issue active; all must be discarded
    rst_n        = 1'b0;
    bus.rd_addr  = {5'd4, 5'd5};
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {5'd4, 5'd5};
    bus.wr_data  = {64'h1111, 64'h2222};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd4;
    repeat (3) step();
    rst_n = 1'b1;
    idle();
    #1;
    chk("rst_count", 64'(bus.busy_count), 64'd0);
    chk("rst_rd0", bus.rd_data[63:0], 64'd0);
    chk("rst_rd1", bus.rd_data[127:64], 64'd0);
    chk("rst_busy", 64'(bus.rd_busy), 64'd0);
    step();
    chk("rst_count_hold", 64'(bus.busy_count), 64'd0);

    // Write and read back, x0 ignores writes
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd5};
    bus.wr_data = {64'd0, 64'hDEAD_BEEF_0000_0001};
    bus.rd_addr = {5'd0, 5'd5};
    step();
    idle();
    #1;
    chk("wr5_read", bus.rd_data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("wr5_notbusy", 64'(bus.rd_busy[0]), 64'd0);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd0};
    bus.wr_data = {64'd0, 64'h1234};
    bus.rd_addr = {5'd5, 5'd0};
    #1;
    chk("x0_bypass", bus.rd_data[63:0], 64'd0);
    step();
    idle();
    #1;
    chk("x0_stored", bus.rd_data[63:0], 64'd0);
    chk("r5_kept", bus.rd_data[127:64], 64'hDEAD_BEEF_0000_0001);

    // Both ports write reg 7; port 1 wins for bypass and storage
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {64'hBB, 64'hAA};
    bus.rd_addr = {5'd7, 5'd7};
    #1;
    chk("byp_prio_rd1", bus.rd_data[127:64], 64'hBB);
    chk("byp_prio_rd0", bus.rd_data[63:0], 64'hBB);
    step();
    idle();
    #1;
    chk("prio_stored", bus.rd_data[127:64], 64'hBB);

    // Issue reg 9: busy only from the next cycle, cleared by writeback
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    bus.rd_addr  = {5'd0, 5'd9};
    #1;
    chk("iss_not_visible", 64'(bus.rd_busy[0]), 64'd0);
    step();
    idle();
    #1;
    chk("iss9_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("iss9_count", 64'(bus.busy_count), 64'd1);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd9};
    bus.wr_data = {64'd0, 64'h55};
    #1;
    chk("wb9_busy_byp", 64'(bus.rd_busy[0]), 64'd0);
    chk("wb9_data_byp", bus.rd_data[63:0], 64'h55);
    chk("wb9_count_pre", 64'(bus.busy_count), 64'd1);
    step();
    idle();
    #1;
    chk("wb9_count_post", 64'(bus.busy_count), 64'd0);
    chk("wb9_busy_post", 64'(bus.rd_busy[0]), 64'd0);

    // Issue and write of the same busy register in one cycle
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    step();
    idle();
    #1;
    chk("r3_count", 64'(bus.busy_count), 64'd1);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    bus.wr_en    = 2'b10;
    bus.wr_addr  = {5'd3, 5'd0};
    bus.wr_data  = {64'h77, 64'd0};
    bus.rd_addr  = {5'd0, 5'd3};
    #1;
    chk("coll_busy_byp", 64'(bus.rd_busy[0]), 64'd0);
    step();
    idle();
    #1;
    chk("coll_data", bus.rd_data[63:0], 64'h77);
    chk("coll_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("coll_count", 64'(bus.busy_count), 64'd1);

    // Saturate the scoreboard, issue to x0 is ignored
    for (int r = 1; r < 32; r++) begin
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'(r);
      step();
    end
    bus.iss_addr = 5'd0;
    step();
    idle();
    bus.rd_addr = {5'd0, 5'd31};
    #1;
    chk("sat_count", 64'(bus.busy_count), 64'd31);
    chk("sat_busy31", 64'(bus.rd_busy[0]), 64'd1);
    chk("sat_busy_x0", 64'(bus.rd_busy[1]), 64'd0);

    // Mid-operation reset clears everything including a pending write
    rst_n       = 1'b0;
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd12};
    bus.wr_data = {64'd0, 64'hCAFE};
    step();
    rst_n = 1'b1;
    idle();
    bus.rd_addr = {5'd12, 5'd31};
    #1;
    chk("rst2_count", 64'(bus.busy_count), 64'd0);
    chk("rst2_busy", 64'(bus.rd_busy), 64'd0);
    chk("rst2_r12", bus.rd_data[127:64], 64'd0);
    bus.rd_addr = {5'd7, 5'd5};
    #1;
    chk("rst2_r5", bus.rd_data[63:0], 64'd0);
    chk("rst2_r7", bus.rd_data[127:64], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
